bouncer_ctl: RTL
================

# bouncer_ctl

Parametrised bouncing-sprite motion controller for the game playfield. Holds one sprite position and diagonal direction, advances it one pixel per axis on qualifying frame ticks, and reflects off a configurable rectangular arena so the sprite never leaves it. Adds a programmable speed divider, a parked/run/paused state machine, start-position clamping and one-cycle bounce event pulses for the sound and score logic. Sits between the frame-tick generator and the sprite renderer.

## Interface
- XW, 7, width of the x coordinate
- YW, 6, width of the y coordinate
- X_MIN, 3, leftmost legal x (inclusive)
- X_MAX, 92, rightmost legal x (inclusive); X_MIN < X_MAX required
- Y_MIN, 14, top legal y (inclusive)
- Y_MAX, 60, bottom legal y (inclusive); Y_MIN < Y_MAX required
- SPD_W, 4, width of the speed divider

- clk  in  1  system clock; all state changes on its rising edge
- clr  in  1  synchronous, active-high reset
- start_x  in  XW  launch x, clamped to [X_MIN, X_MAX]
- start_y  in  YW  launch y, clamped to [Y_MIN, Y_MAX]
- start_dir  in  2  launch direction
- tick  in  1  frame tick, one-cycle pulse
- speed  in  SPD_W  move once every speed+1 ticks
- launch  in  1  pulse: leave PARKED and start moving
- pause  in  1  level: freeze motion while high
- pos_x  out  XW  registered sprite x
- pos_y  out  YW  registered sprite y
- dir  out  2  registered direction; dir[1]=1 moves +x, dir[1]=0 moves -x; dir[0]=0 moves +y, dir[0]=1 moves -y
- bounce_x  out  1  one-cycle pulse: x reflected on this move
- bounce_y  out  1  one-cycle pulse: y reflected on this move
- running  out  1  high in RUN state

## Operation
- States: PARKED, RUN, PAUSED.
- clr (any state): go to PARKED; pos_x = clamp(start_x), pos_y = clamp(start_y), dir = start_dir, divider = 0, bounce_x = bounce_y = 0, running = 0.
- PARKED: every cycle, pos and dir reload from the clamped start inputs, so the menu can reposition the sprite. Divider is held at 0. If launch=1, go to RUN; pause is ignored in this state.
- RUN: if pause=1, go to PAUSED with no move that cycle. Otherwise, on tick=1: if divider == speed, make a move and set divider to 0; else increment divider.
- PAUSED: pos, dir and divider are frozen; tick is ignored. When pause=0, return to RUN. A launch in RUN or PAUSED is ignored.
- Move (each axis independently):
  - Reflect first: if moving + and pos >= MAX, or moving - and pos <= MIN, invert that dir bit and pulse that axis's bounce output.
  - Then step 1 pixel using the possibly-updated direction.
  - Results: the sprite never leaves the arena. A sprite at MAX moving + ends at MAX-1. A corner hit reflects both axes in the same move.
- Clamp: values below MIN become MIN and values above MAX become MAX. Comparisons are unsigned at full width, so no wrap-around is possible.
- If speed changes while the divider is above the new speed, the next tick makes a move (use >= compare) and resets the divider.

## Timing
- All outputs are registered. A move's new pos, dir and bounce pulses appear together on the edge that samples the qualifying tick.
- bounce_x and bounce_y are high for exactly one cycle per reflecting move, otherwise 0.
- launch sampled in PARKED: running=1 from the next cycle. The first move needs speed+1 further ticks.
- pause: effective on the edge that samples it. A tick on that same edge is discarded.
- clr overrides tick, launch and pause on the same edge.

## Test plan
- Reset and park: clr with start=(50,30,2'b10) → pos (50,30), dir 10, running 0; then change start_x to 120 → pos_x 92 next cycle.
- Basic motion at speed 0: launch, 3 ticks from (50,30,dir 10) → (51,31), (52,32), (53,33); no bounce pulses.
- Divider at speed 2: 9 ticks → exactly 3 moves, on ticks 3, 6 and 9.
- Edge reflection: start (91,30,dir 10), speed 0 → (92,31), then (91,32) with dir 00 and bounce_x=1 for one cycle.
- Corner: start (92,60,dir 10) → first move gives (91,59), dir 01, both bounce pulses high in the same cycle.
- Pause and clr mid-run: pause for 5 ticks → pos unchanged; release → motion resumes with the divider value intact; then clr while running → PARKED at the clamped start, divider 0.

Source files
------------

// File: rtl/bouncer_ctl.sv
// Bouncing-sprite motion controller: holds one sprite position and diagonal
// direction, steps it on divided frame ticks and reflects it off the arena walls.
module bouncer_ctl #(
    parameter int XW    = 7,
    parameter int YW    = 6,
    parameter int X_MIN = 3,
    parameter int X_MAX = 92,
    parameter int Y_MIN = 14,
    parameter int Y_MAX = 60,
    parameter int SPD_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [XW-1:0]    start_x,
    input  logic [YW-1:0]    start_y,
    input  logic [1:0]       start_dir,
    input  logic             tick,
    input  logic [SPD_W-1:0] speed,
    input  logic             launch,
    input  logic             pause,
    output logic [XW-1:0]    pos_x,
    output logic [YW-1:0]    pos_y,
    output logic [1:0]       dir,
    output logic             bounce_x,
    output logic             bounce_y,
    output logic             running
);

    localparam logic [1:0] PARKED = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    localparam logic [XW-1:0] XLO = XW'(X_MIN);
    localparam logic [XW-1:0] XHI = XW'(X_MAX);
    localparam logic [YW-1:0] YLO = YW'(Y_MIN);
    localparam logic [YW-1:0] YHI = YW'(Y_MAX);

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    posX_q, posX_d;
    logic [YW-1:0]    posY_q, posY_d;
    logic [1:0]       dir_q, dir_d;
    logic [SPD_W-1:0] div_q, div_d;
    logic             bounceX_q, bounceX_d;
    logic             bounceY_q, bounceY_d;
    logic             running_q, running_d;

    logic [XW-1:0]    clampX, moveX;
    logic [YW-1:0]    clampY, moveY;
    logic             plusX, plusY, hitX, hitY, newPlusX, newPlusY;

    // Unsigned full-width clamps of the launch position into the arena.
    always_comb begin
        clampX = start_x;
        if (start_x < XLO) clampX = XLO;
        else if (start_x > XHI) clampX = XHI;
        clampY = start_y;
        if (start_y < YLO) clampY = YLO;
        else if (start_y > YHI) clampY = YHI;
    end

    // Candidate move: reflect at a wall first, then step with the updated direction.
    always_comb begin
        plusX    = dir_q[1];
        plusY    = ~dir_q[0];
        hitX     = plusX ? (posX_q >= XHI) : (posX_q <= XLO);
        hitY     = plusY ? (posY_q >= YHI) : (posY_q <= YLO);
        newPlusX = plusX ^ hitX;
        newPlusY = plusY ^ hitY;
        moveX    = newPlusX ? posX_q + XW'(1) : posX_q - XW'(1);
        moveY    = newPlusY ? posY_q + YW'(1) : posY_q - YW'(1);
    end

    always_comb begin
        state_d   = state_q;
        posX_d    = posX_q;
        posY_d    = posY_q;
        dir_d     = dir_q;
        div_d     = div_q;
        bounceX_d = 1'b0;
        bounceY_d = 1'b0;
        case (state_q)
            PARKED: begin
                posX_d = clampX;
                posY_d = clampY;
                dir_d  = start_dir;
                div_d  = '0;
                if (launch) state_d = RUN;
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    // >= lets a freshly lowered speed take effect on the very next tick.
                    if (div_q >= speed) begin
                        div_d     = '0;
                        posX_d    = moveX;
                        posY_d    = moveY;
                        dir_d     = {newPlusX, ~newPlusY};
                        bounceX_d = hitX;
                        bounceY_d = hitY;
                    end else begin
                        div_d = div_q + SPD_W'(1);
                    end
                end
            end
            PAUSED: begin
                if (!pause) state_d = RUN;
            end
            default: state_d = PARKED;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= PARKED;
            posX_q    <= clampX;
            posY_q    <= clampY;
            dir_q     <= start_dir;
            div_q     <= '0;
            bounceX_q <= 1'b0;
            bounceY_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            posX_q    <= posX_d;
            posY_q    <= posY_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            bounceX_q <= bounceX_d;
            bounceY_q <= bounceY_d;
            running_q <= running_d;
        end
    end

    assign pos_x    = posX_q;
    assign pos_y    = posY_q;
    assign dir      = dir_q;
    assign bounce_x = bounceX_q;
    assign bounce_y = bounceY_q;
    assign running  = running_q;

endmodule
